// File: rtl/sudoku_pkg.sv
// Shared constants for the Sudoku display path: digit count and active-low
// seven-segment glyphs ordered {Ca..Cg}.
package sudoku_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Hex glyphs as already used on the board (lower-case b and d).
    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'b0000001, // 0
        7'b1001111, // 1
        7'b0010010, // 2
        7'b0000110, // 3
        7'b1001100, // 4
        7'b0100100, // 5
        7'b0100000, // 6
        7'b0001111, // 7
        7'b0000000, // 8
        7'b0000100, // 9
        7'b0001000, // A
        7'b1100000, // b
        7'b0110001, // C
        7'b1000010, // d
        7'b0110000, // E
        7'b0111000  // F
    };

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational nibble-to-glyph lookup; reusable by any display path that
// needs the board's hex glyphs.
module ssd_hex_decoder
    import sudoku_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_HEX[nibble];
    end

endmodule

// File: rtl/sudoku_ssd_driver.sv
// Four-digit time-multiplexed seven-segment driver with guard interval,
// blanking, blinking and tear-free frame-aligned loads. SSD_DP_STATUS_EN adds DpMask.
module sudoku_ssd_driver
    import sudoku_pkg::*;
#(
    parameter int SCAN_BITS  = 18,
    parameter int GUARD      = 16,
    parameter int BLINK_BITS = 25
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [15:0] Digits,
    input  logic        Load,
    input  logic [3:0]  Blank,
    input  logic [3:0]  Blink,
`ifdef SSD_DP_STATUS_EN
    input  logic [3:0]  DpMask,
`endif
    output logic [7:0]  An,
    output logic [6:0]  Seg,
    output logic        Dp,
    output logic        FrameStart
);

    localparam logic [SCAN_BITS-1:0] GUARD_OFF = SCAN_BITS'(GUARD);

    logic [SCAN_BITS+1:0]  scan_cnt;
    logic [BLINK_BITS-1:0] blink_cnt;

    logic [15:0] pend_digits, disp_digits;
    logic [3:0]  pend_blank, disp_blank;
    logic [3:0]  pend_blink, disp_blink;

    logic        frame_edge;
    logic [1:0]  slot;
    logic        in_window;
    logic        visible;
    logic [15:0] cur_digits;
    logic [3:0]  cur_blank, cur_blink;
    logic [3:0]  nibble;
    logic [6:0]  glyph;
    logic        dp_next;

    assign frame_edge = (scan_cnt == '0);
    assign slot       = scan_cnt[SCAN_BITS+1:SCAN_BITS];
    assign in_window  = (scan_cnt[SCAN_BITS-1:0] >= GUARD_OFF);

    // At the frame boundary the output stage already sees the data being
    // latched into the display registers, so a coincident Load shows at once.
    always_comb begin
        cur_digits = disp_digits;
        cur_blank  = disp_blank;
        cur_blink  = disp_blink;
        if (frame_edge) begin
            cur_digits = Load ? Digits : pend_digits;
            cur_blank  = Load ? Blank  : pend_blank;
            cur_blink  = Load ? Blink  : pend_blink;
        end
    end

    assign visible = in_window && !cur_blank[slot]
                     && !(cur_blink[slot] && blink_cnt[BLINK_BITS-1]);
    assign nibble  = cur_digits[{slot, 2'b00} +: 4];

    ssd_hex_decoder u_decoder (
        .nibble (nibble),
        .seg    (glyph)
    );

`ifdef SSD_DP_STATUS_EN
    logic [3:0] pend_dp, disp_dp, cur_dp;

    always_comb begin
        cur_dp = disp_dp;
        if (frame_edge) begin
            cur_dp = Load ? DpMask : pend_dp;
        end
    end

    assign dp_next = visible ? ~cur_dp[slot] : 1'b1;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pend_dp <= '0;
            disp_dp <= '0;
        end else begin
            if (Load) begin
                pend_dp <= DpMask;
            end
            if (frame_edge) begin
                disp_dp <= cur_dp;
            end
        end
    end
`else
    assign dp_next = 1'b1;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            scan_cnt    <= '0;
            blink_cnt   <= '0;
            pend_digits <= '0;
            pend_blank  <= '0;
            pend_blink  <= '0;
            disp_digits <= '0;
            disp_blank  <= '0;
            disp_blink  <= '0;
            An          <= 8'hFF;
            Seg         <= SEG_BLANK;
            Dp          <= 1'b1;
            FrameStart  <= 1'b0;
        end else begin
            scan_cnt  <= scan_cnt + 1'b1;
            blink_cnt <= blink_cnt + 1'b1;
            if (Load) begin
                pend_digits <= Digits;
                pend_blank  <= Blank;
                pend_blink  <= Blink;
            end
            if (frame_edge) begin
                disp_digits <= cur_digits;
                disp_blank  <= cur_blank;
                disp_blink  <= cur_blink;
            end
            An         <= visible ? ~(8'd1 << slot) : 8'hFF;
            Seg        <= visible ? glyph : SEG_BLANK;
            Dp         <= dp_next;
            FrameStart <= frame_edge;
        end
    end

endmodule

// File: tb/tb_sudoku_ssd_driver.sv
// Scoreboard bench for sudoku_ssd_driver with SCAN_BITS=4, GUARD=2, BLINK_BITS=6
// (64-cycle frames); honours SSD_DP_STATUS_EN.
module tb_sudoku_ssd_driver;

    logic        Clk;
    logic        Reset_n;
    logic [15:0] Digits;
    logic        Load;
    logic [3:0]  Blank;
    logic [3:0]  Blink;
    logic [3:0]  dp_mask;
    logic [7:0]  An;
    logic [6:0]  Seg;
    logic        Dp;
    logic        FrameStart;

`ifdef SSD_DP_STATUS_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    sudoku_ssd_driver #(
        .SCAN_BITS  (4),
        .GUARD      (2),
        .BLINK_BITS (6)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Digits     (Digits),
        .Load       (Load),
        .Blank      (Blank),
        .Blink      (Blink),
`ifdef SSD_DP_STATUS_EN
        .DpMask     (dp_mask),
`endif
        .An         (An),
        .Seg        (Seg),
        .Dp         (Dp),
        .FrameStart (FrameStart)
    );

    // clock / reset-relative cycle count (cyc = number of edges since release)
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int cyc = 0;
    always @(posedge Clk) begin
        if (!Reset_n) cyc = 0;
        else cyc = cyc + 1;
    end

    int checks = 0;
    int failures = 0;

    // entry = {cyc[15:0], An, Seg, Dp}
    logic [31:0] exp_q[$];

    logic [6:0] glyph [0:15] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    logic [7:0] an_code [0:3] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};

    task automatic push_frame(input int f, input logic [15:0] d, input logic [3:0] show,
                              input logic [3:0] dpm, input int last_off);
        int          c;
        logic [3:0]  nib;
        logic        dp;
        for (int s = 0; s < 4; s++) begin
            if (show[s]) begin
                nib = d[s*4 +: 4];
                dp  = !(DP_EN && dpm[s]);
                for (int o = 2; o <= last_off; o++) begin
                    c = 64 * f + 16 * s + o + 1;
                    exp_q.push_back({c[15:0], an_code[s], glyph[nib], dp});
                end
            end
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) begin
            @(posedge Clk);
            #2;
        end
    endtask

    task automatic load_at(input int k, input logic [15:0] d, input logic [3:0] bl,
                           input logic [3:0] bk, input logic [3:0] dpm);
        wait_cyc(k);
        Digits  = d;
        Blank   = bl;
        Blink   = bk;
        dp_mask = dpm;
        Load    = 1'b1;
        @(posedge Clk);
        #2;
        Load = 1'b0;
    endtask

    // monitor: pops an expected entry for every visible-digit cycle
    logic [31:0] exp_e;
    logic        exp_fs;
    always @(negedge Clk) begin
        if (An != 8'hFF) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_digit cyc=%0d an=%h seg=%b dp=%b", cyc, An, Seg, Dp);
            end else begin
                exp_e = exp_q.pop_front();
                if ({cyc[15:0], An, Seg, Dp} !== exp_e) begin
                    failures++;
                    $display("FAIL digit got cyc=%0d an=%h seg=%b dp=%b expected cyc=%0d an=%h seg=%b dp=%b",
                             cyc, An, Seg, Dp, exp_e[31:16], exp_e[15:8], exp_e[7:1], exp_e[0]);
                end
            end
        end else begin
            checks++;
            if (Seg !== 7'h7F || Dp !== 1'b1) begin
                failures++;
                $display("FAIL idle_outputs cyc=%0d seg=%b dp=%b expected seg=1111111 dp=1", cyc, Seg, Dp);
            end
        end
        exp_fs = Reset_n && (cyc > 0) && (((cyc - 1) % 64) == 0);
        if (exp_fs || FrameStart) begin
            checks++;
            if (FrameStart !== exp_fs) begin
                failures++;
                $display("FAIL frame_start cyc=%0d got=%b expected=%b", cyc, FrameStart, exp_fs);
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout cyc=%0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        Reset_n = 1'b0;
        Digits  = '0;
        Load    = 1'b0;
        Blank   = '0;
        Blink   = '0;
        dp_mask = '0;
        repeat (3) @(posedge Clk);
        #2;
        check_val("reset_an", {24'h0, An}, 32'hFF);
        check_val("reset_seg", {25'h0, Seg}, 32'h7F);
        check_val("reset_dp", {31'h0, Dp}, 32'h1);
        check_val("reset_frame_start", {31'h0, FrameStart}, 32'h0);
        Reset_n = 1'b1;

        push_frame(0, 16'h0000, 4'hF, 4'h0, 15);
        load_at(10, 16'h3A07, 4'h0, 4'h0, 4'h0);
        push_frame(1, 16'h3A07, 4'hF, 4'h0, 15);
        // mid-frame load in slot 2: frame 1 keeps 3A07
        load_at(101, 16'h1111, 4'h0, 4'h0, 4'h0);
        push_frame(2, 16'h1111, 4'hF, 4'h0, 15);
        // load on the boundary cycle: shows in the same frame
        load_at(192, 16'hC4D9, 4'h0, 4'h0, 4'h0);
        push_frame(3, 16'hC4D9, 4'hF, 4'h0, 15);
        // slot1 blanked, slot2 blinking (slots 2/3 fall in phase 1)
        load_at(200, 16'h8F6E, 4'b0010, 4'b0100, 4'h0);
        push_frame(4, 16'h8F6E, 4'b1001, 4'h0, 15);
        load_at(270, 16'h2345, 4'h0, 4'b1001, 4'h0);
        push_frame(5, 16'h2345, 4'b0111, 4'h0, 15);
        load_at(330, 16'hFEDB, 4'h0, 4'h0, 4'b1000);
        push_frame(6, 16'hFEDB, 4'hF, 4'b1000, 15);
        push_frame(7, 16'hFEDB, 4'b0001, 4'b1000, 5);
        load_at(451, 16'h9999, 4'h0, 4'h0, 4'h0);

        // asynchronous reset mid-digit; pending 9999 must be lost
        wait_cyc(455);
        Reset_n = 1'b0;
        #1;
        check_val("midreset_an", {24'h0, An}, 32'hFF);
        check_val("midreset_seg", {25'h0, Seg}, 32'h7F);
        check_val("midreset_dp", {31'h0, Dp}, 32'h1);
        check_val("midreset_frame_start", {31'h0, FrameStart}, 32'h0);
        repeat (2) @(posedge Clk);
        #2;
        Reset_n = 1'b1;
        push_frame(0, 16'h0000, 4'hF, 4'h0, 15);
        push_frame(1, 16'h0000, 4'hF, 4'h0, 15);
        wait_cyc(130);

        check_val("queue_drained", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
